if_stage: RTL and testbench

- Instruction-fetch stage of the 32-bit RISC-V five-stage pipeline.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched word, its PC and PC+4 into the IF/ID pipeline register.
- Redirects the PC to a jump/branch target supplied by a later stage, and flushes the wrong-path instruction when it does so.

---
 rtl/if_stage.sv | 59 +++++
 tb/tb_if_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// RISC-V instruction fetch: PC register, imem address, IF/ID register; redirect flushes with a NOP.
// Latency: ins_addr combinational from PC, fetch-to-pipe 1 cycle; no stall/backpressure, PC advances every cycle.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'd64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        control_j,
  input  logic [31:0] pc_j,
  input  logic [31:0] ins_data,
  output logic [31:0] ins_addr,
  output logic [31:0] pipe_pc,
  output logic [31:0] pipe_pc4,
  output logic [31:0] pipe_data
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] data;
  } ifid_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  ifid_t       ifid_q, ifid_d;

  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    pc_d        = pc_plus4;
    ifid_d.pc   = pc_q;
    ifid_d.pc4  = pc_plus4;
    ifid_d.data = ins_data;
    // A taken redirect means the word fetched this cycle is wrong-path.
    if (control_j) begin
      pc_d        = pc_j;
      ifid_d.data = NOP_INSTR;
    end
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc_q        <= RESET_PC;
      ifid_q.pc   <= 32'd0;
      ifid_q.pc4  <= 32'd0;
      ifid_q.data <= NOP_INSTR;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign ins_addr  = pc_q;
  assign pipe_pc   = ifid_q.pc;
  assign pipe_pc4  = ifid_q.pc4;
  assign pipe_data = ifid_q.data;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written multi-cycle sequences, random run vs reference model.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h002081B3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        control_j = 1'b0;
  logic [31:0] pc_j = 32'd0;
  logic [31:0] ins_data;
  logic [31:0] ins_addr, pipe_pc, pipe_pc4, pipe_data;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .control_j (control_j),
    .pc_j      (pc_j),
    .ins_data  (ins_data),
    .ins_addr  (ins_addr),
    .pipe_pc   (pipe_pc),
    .pipe_pc4  (pipe_pc4),
    .pipe_data (pipe_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'd64) return ADDI;
    if (a == 32'd68) return ADD;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0003;
  endfunction

  assign ins_data = imem(ins_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs for one rising edge, then settle 1 time unit past it.
  task automatic cyc(input logic rst, input logic cj, input logic [31:0] tgt);
    reset_n   = rst;
    control_j = cj;
    pc_j      = tgt;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        cj;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[13];

  // Reference model state: program counter plus the IF/ID triple.
  logic [31:0] m_pc, m_ppc, m_ppc4, m_pdata;

  task automatic model_step(input logic rst, input logic cj, input logic [31:0] tgt);
    if (rst) begin
      m_pc = 32'd64; m_ppc = 32'd0; m_ppc4 = 32'd0; m_pdata = NOP;
    end else begin
      m_ppc   = m_pc;
      m_ppc4  = m_pc + 32'd4;
      m_pdata = cj ? NOP : imem(m_pc);
      m_pc    = cj ? tgt : m_pc + 32'd4;
    end
  endtask

  initial begin
    bit found;
    vecs[0]  = '{1'b1, 1'b0, 32'd0,         32'd64,        32'd0,         32'd0,   NOP};
    vecs[1]  = '{1'b0, 1'b0, 32'd0,         32'd68,        32'd64,        32'd68,  ADDI};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,         32'd72,        32'd68,        32'd72,  ADD};
    vecs[3]  = '{1'b0, 1'b0, 32'd0,         32'd76,        32'd72,        32'd76,  imem(32'd72)};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,         32'd80,        32'd76,        32'd80,  imem(32'd76)};
    vecs[5]  = '{1'b0, 1'b1, 32'd68,        32'd68,        32'd80,        32'd84,  NOP};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,         32'd72,        32'd68,        32'd72,  ADD};
    vecs[7]  = '{1'b0, 1'b1, 32'd100,       32'd100,       32'd72,        32'd76,  NOP};
    vecs[8]  = '{1'b0, 1'b1, 32'd64,        32'd64,        32'd100,       32'd104, NOP};
    vecs[9]  = '{1'b1, 1'b1, 32'd68,        32'd64,        32'd0,         32'd0,   NOP};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFFFFFC,  32'hFFFFFFFC,  32'd64,        32'd68,  NOP};
    vecs[11] = '{1'b0, 1'b0, 32'd0,         32'd0,         32'hFFFFFFFC,  32'd0,   imem(32'hFFFFFFFC)};
    vecs[12] = '{1'b0, 1'b0, 32'd0,         32'd4,         32'd0,         32'd4,   imem(32'd0)};

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].rst, vecs[i].cj, vecs[i].tgt);
      chk($sformatf("vec%0d ins_addr", i),  ins_addr,  vecs[i].e_addr);
      chk($sformatf("vec%0d pipe_pc", i),   pipe_pc,   vecs[i].e_pc);
      chk($sformatf("vec%0d pipe_pc4", i),  pipe_pc4,  vecs[i].e_pc4);
      chk($sformatf("vec%0d pipe_data", i), pipe_data, vecs[i].e_data);
    end

    // Mid-run reset once the PC reaches 116.
    cyc(1'b1, 1'b0, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ins_addr == 32'd116) found = 1'b1;
      else cyc(1'b0, 1'b0, 32'd0);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midrst_reach116: got %h expected 00000074 within 40 cycles", ins_addr);
    end
    cyc(1'b1, 1'b0, 32'd0);
    chk("midrst ins_addr", ins_addr, 32'd64);
    chk("midrst pipe_data", pipe_data, NOP);
    cyc(1'b0, 1'b0, 32'd0);
    chk("midrst resume1 ins_addr", ins_addr, 32'd68);
    chk("midrst resume1 pipe_pc", pipe_pc, 32'd64);
    chk("midrst resume1 pipe_data", pipe_data, ADDI);
    cyc(1'b0, 1'b0, 32'd0);
    chk("midrst resume2 ins_addr", ins_addr, 32'd72);

    // Redirect issued the same edge reset drops must still be ignored during reset only.
    cyc(1'b1, 1'b1, 32'h00001000);
    chk("rst_over_j ins_addr", ins_addr, 32'd64);
    cyc(1'b0, 1'b1, 32'h00001002);
    chk("unaligned ins_addr", ins_addr, 32'h00001002);
    chk("unaligned pipe_pc4", pipe_pc4, 32'd68);

    // Randomized run against the reference model.
    cyc(1'b1, 1'b0, 32'd0);
    model_step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic        r, j;
      logic [31:0] t;
      r = ($urandom_range(0, 31) == 0);
      j = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: t = $urandom;
        1: t = 32'hFFFFFFF0 + {$urandom_range(0, 3), 2'b00};
        default: t = {$urandom_range(0, 255), 2'b00};
      endcase
      cyc(r, j, t);
      model_step(r, j, t);
      chk($sformatf("rand%0d ins_addr", i),  ins_addr,  m_pc);
      chk($sformatf("rand%0d pipe_pc", i),   pipe_pc,   m_ppc);
      chk($sformatf("rand%0d pipe_pc4", i),  pipe_pc4,  m_ppc4);
      chk($sformatf("rand%0d pipe_data", i), pipe_data, m_pdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
